// File: rtl/gray_step_decoder.sv
// Synchronizes, debounces and decodes a reflected Gray code from pins into step events and a position count.
// Define GRAY_DEC_ERR_CNT_EN to build the saturating illegal-jump counter on err_cnt.
module gray_step_decoder #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             dir,
  output logic             err,
  output logic [7:0]       position,
  output logic [7:0]       err_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_pend;
  logic [WIDTH-1:0] r_pendBin;

  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_obPlus;
  logic [WIDTH-1:0] w_obMinus;
  logic             w_isUp;
  logic             w_isDown;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    w_nb      = gray2bin(r_cand);
    w_obPlus  = bin_out + WIDTH'(1);
    w_obMinus = bin_out - WIDTH'(1);
    w_isUp    = (r_pendBin == w_obPlus);
    w_isDown  = (r_pendBin == w_obMinus);
  end

  // The commit decision is registered into r_pend so outputs update one edge later.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_pend    <= 1'b0;
      r_pendBin <= '0;
    end else begin
      r_sync1 <= gray_in;
      r_sync2 <= r_sync1;
      r_pend  <= 1'b0;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_cand != r_acc) begin
        r_acc     <= r_cand;
        r_pend    <= 1'b1;
        r_pendBin <= w_nb;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bin_out  <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      dir      <= 1'b1;
      position <= 8'd0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (r_pend) begin
        bin_out <= r_pendBin;
        if (w_isUp) begin
          valid    <= 1'b1;
          dir      <= 1'b1;
          position <= position + 8'd1;
        end else if (w_isDown) begin
          valid    <= 1'b1;
          dir      <= 1'b0;
          position <= position - 8'd1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef GRAY_DEC_ERR_CNT_EN
  logic [7:0] r_errCnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_errCnt <= 8'd0;
    end else if (r_pend && !w_isUp && !w_isDown && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign err_cnt = r_errCnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray_step_decoder.sv
// Randomized bench for gray_step_decoder: per-cycle outputs are compared with a run-length based reference model.
module tb_gray_step_decoder;

  localparam int W   = 4;
  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic       clk;
  logic       arst_n;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       valid;
  logic       dir;
  logic       err;
  logic [7:0] position;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] stim[$];
  int         eventAt[$];

  gray_step_decoder #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .valid    (valid),
    .dir      (dir),
    .err      (err),
    .position (position),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    gray_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic addSeg(input logic [3:0] code, input int dur);
    repeat (dur) stim.push_back(code);
  endtask

  function automatic logic [3:0] grayOf(input int i);
    return 4'(i ^ (i >> 1));
  endfunction

  function automatic int grayIndex(input logic [3:0] g);
    for (int i = 0; i < 16; i++) begin
      if (grayOf(i) == g) return i;
    end
    return -1;
  endfunction

  // A run of one code lasting D+1 or more cycles is accepted; its event appears LAT edges after the run starts.
  task automatic buildModel();
    int c;
    int len;
    logic [3:0] accepted;
    accepted = 4'd0;
    for (int i = 0; i < stim.size(); i++) eventAt.push_back(-1);
    c = 0;
    while (c < stim.size()) begin
      len = 1;
      while ((c + len < stim.size()) && (stim[c+len] == stim[c])) len++;
      if ((len >= D + 1) && (stim[c] != accepted)) begin
        if (c + LAT < stim.size()) eventAt[c+LAT] = int'(stim[c]);
        accepted = stim[c];
      end
      c += len;
    end
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, ".bin_out"}, int'(bin_out), 0);
    checkOutput({where, ".valid"}, int'(valid), 0);
    checkOutput({where, ".err"}, int'(err), 0);
    checkOutput({where, ".dir"}, int'(dir), 1);
    checkOutput({where, ".position"}, int'(position), 0);
    checkOutput({where, ".err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    int mBin, mDir, mPos, mErrCnt, expValid, expErr, nb, prev, idx, r;
    int expErrCntAfter;

    gray_in = 4'd0;
    arst_n  = 1'b1;
    #1 arst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    arst_n = 1'b1;

    addSeg(4'b0000, 10);
    for (int i = 1; i < 16; i++) addSeg(grayOf(i), 10);
    addSeg(4'b0000, 10);
    addSeg(4'b0001, 3);
    addSeg(4'b0000, 10);
    addSeg(4'b0001, 4);
    addSeg(4'b0000, 10);
    addSeg(4'b0001, 5);
    addSeg(4'b0000, 10);
    addSeg(4'b0110, 10);
    addSeg(4'b0111, 10);
    addSeg(4'b0000, 10);
    addSeg(4'b1000, 10);
    addSeg(4'b1001, 10);
    prev = grayIndex(4'b1001);
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) idx = (prev + 1) % 16;
      else if (r < 8) idx = (prev + 15) % 16;
      else idx = int'($urandom_range(0, 15));
      if (idx == prev) idx = (prev + 3) % 16;
      addSeg(grayOf(idx), int'($urandom_range(1, 12)));
      prev = idx;
    end
    addSeg(grayOf(prev), 12);
    buildModel();

    mBin = 0; mDir = 1; mPos = 0; mErrCnt = 0;
    for (int c = 0; c < stim.size(); c++) begin
      applyStimulus(stim[c]);
      expValid = 0;
      expErr   = 0;
      if (eventAt[c] >= 0) begin
        nb = grayIndex(4'(eventAt[c]));
        if (nb == (mBin + 1) % 16) begin
          expValid = 1; mDir = 1; mPos = (mPos + 1) % 256;
        end else if (nb == (mBin + 15) % 16) begin
          expValid = 1; mDir = 0; mPos = (mPos + 255) % 256;
        end else begin
          expErr = 1;
`ifdef GRAY_DEC_ERR_CNT_EN
          if (mErrCnt < 255) mErrCnt++;
`endif
        end
        mBin = nb;
      end
      checkOutput($sformatf("bin_out@%0d", c), int'(bin_out), mBin);
      checkOutput($sformatf("valid@%0d", c), int'(valid), expValid);
      checkOutput($sformatf("err@%0d", c), int'(err), expErr);
      checkOutput($sformatf("dir@%0d", c), int'(dir), mDir);
      checkOutput($sformatf("position@%0d", c), int'(position), mPos);
      checkOutput($sformatf("err_cnt@%0d", c), int'(err_cnt), mErrCnt);
    end

    // Reset dropped between edges while a new code is still being debounced.
    applyStimulus(4'b0101);
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    gray_in = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
`ifdef GRAY_DEC_ERR_CNT_EN
    expErrCntAfter = 1;
`else
    expErrCntAfter = 0;
`endif
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rel.err@%0d", k), int'(err), (k == LAT) ? 1 : 0);
      checkOutput($sformatf("rel.valid@%0d", k), int'(valid), 0);
      checkOutput($sformatf("rel.bin_out@%0d", k), int'(bin_out), (k >= LAT) ? 2 : 0);
      checkOutput($sformatf("rel.position@%0d", k), int'(position), 0);
      checkOutput($sformatf("rel.dir@%0d", k), int'(dir), 1);
      checkOutput($sformatf("rel.err_cnt@%0d", k), int'(err_cnt), (k >= LAT) ? expErrCntAfter : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Receives a 4-bit reflected Gray code from external pins, such as the LED/step code produced by the board's Gray sequence generator looped back through a header or a rotary/absolute encoder. It synchronizes and debounces the code, then converts it to binary. Each accepted change is classified as a step up, a step down or an illegal jump. The block keeps an 8-bit wrapping position count and drives status outputs for the board LEDs or a downstream controller.

## Interface
- WIDTH, 4: Gray code width in bits; must be at least 2.
- DEBOUNCE_CYCLES, 4: number of consecutive stable synchronized samples required before a code is accepted; must be at least 1; board build uses 1_000_000.
- clk  in  1: system clock; all state changes on the rising edge.
- arst_n  in  1: reset, asynchronous, active-low. Assertion clears all state immediately. Deassertion is synchronized to clk outside this block.
- gray_in  in  WIDTH: asynchronous Gray code from pins.
- bin_out  out  WIDTH: binary value of the last accepted code (registered).
- valid  out  1: one-cycle pulse on each accepted legal step.
- dir  out  1: direction of the last legal step; 1 = up (+1), 0 = down (−1).
- err  out  1: one-cycle pulse on each accepted illegal jump.
- position  out  8: up/down step count, wraps modulo 256.
- err_cnt  out  8: saturating count of illegal jumps; present only with the configuration macro.

## Operation
- **Synchronizer.** Two-flop chain per bit. The second stage is `s`.
- **Debounce.** The block holds a candidate register `cand` and a counter `cnt` of width clog2(DEBOUNCE_CYCLES+1). On each edge:
  - If `s != cand`: `cand <= s`, `cnt <= 0`.
  - Else, if `cnt < DEBOUNCE_CYCLES-1`: `cnt++`.
  - Else (`cnt == DEBOUNCE_CYCLES-1`) and `cand != acc`: commit.
  - `acc` is the accepted Gray register.
- **Single commit.** Each stable code commits at most once. A code equal to `acc` never commits.
- **Decode.** `bin[WIDTH-1] = g[WIDTH-1]`; `bin[i] = bin[i+1] ^ g[i]`. `nb` is the decoded `cand`; `ob` is the current `bin_out`.
- **Classify on commit.** All arithmetic is modulo 2^WIDTH.
  - `nb == ob+1`: legal up. `valid=1`, `dir<=1`, `position<=position+1`.
  - `nb == ob-1`: legal down. `valid=1`, `dir<=0`, `position<=position-1`.
  - Otherwise: illegal jump. `err=1`. `dir` and `position` are unchanged. `err_cnt` increments and saturates at 255.
  - In every case: `acc<=cand`, `bin_out<=nb`. The decoder resynchronizes to the new code.
- **Pulse width.** `valid` and `err` are mutually exclusive. Each is high for exactly one cycle, on the cycle following the commit edge.
- **Wrap-around.** 15→0 is up and 0→15 is down (WIDTH=4). `position` wraps 255↔0 silently.
- **Reset values.** `sync=0`, `cand=0`, `cnt=0`, `acc=0`, `bin_out=0`, `valid=0`, `err=0`, `dir=1`, `position=0`, `err_cnt=0`. If pins read code 0 out of reset, no event is generated.
- **Reset mid-operation.** All in-flight debounce state is discarded. A code held through reset is re-debounced from scratch after release and commits only if it differs from 0.

## Timing
- **Latency.** `gray_in` changes before edge 0 and then holds stable. Commit, and the update of all registered outputs, happens at edge DEBOUNCE_CYCLES+3. `valid`/`err` are high from that edge until the next edge.
- **Glitch rejection.** A change lasting fewer than DEBOUNCE_CYCLES+1 synchronized samples is rejected, and `cnt` restarts.
- **Throughput.** Back-to-back codes each held for at least DEBOUNCE_CYCLES+1 cycles are all captured in order.
- **Outputs.** All outputs are registered. There is no combinational path from `gray_in`.

## Configuration
- `GRAY_DEC_ERR_CNT_EN` defined: the `err_cnt` 8-bit saturating counter is built.
- `GRAY_DEC_ERR_CNT_EN` undefined: the counter register is omitted and the `err_cnt` port is tied to 0.
- The `err` pulse and every other behaviour are identical in both builds.

## Test plan
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4.
- **Full upward sequence.** After reset, drive 0000,0001,0011,…,1000,0000, each code held 10 cycles. Required: 16 `valid` pulses, no `err`, `dir=1` throughout, `bin_out` stepping 1..15,0, final `position=16`.
- **Downward wrap.** After reset, drive 1000 then 1001. Required: `valid` twice, `dir=0`, `bin_out` 15 then 14, `position` 255 then 254.
- **Glitch rejection.** From 0000, pulse 0001 for 3 cycles, then return to 0000. Required: no `valid`/`err`; `bin_out`, `position` and `cnt`-driven state stay at 0.
- **Illegal jump and recovery.** From 0000, drive 0110 (bin 4). Required: `err` pulse, `bin_out=4`, `position=0`, `err_cnt=1` when enabled. Then drive 0111 (bin 5). Required: `valid`, `dir=1`, `position=1`.
- **Latency.** A single step is stable before edge 0. Required: `bin_out` changes and `valid` rises at exactly edge 7.
- **Reset mid-operation.** Drop `arst_n` mid-debounce, between edges. Required: all outputs show their reset values before the next clock edge. After release with 0011 held, exactly one `err` occurs (0→2 is illegal), at edge 7 after release.
